max7219_frame_rx: RTL and testbench
===================================

# max7219_frame_rx

Serial frame receiver for the MAX7219 3-wire interface (LOAD/CLK/DIN), built as the far end of our LED driver serializer. It samples the link in the system clock domain, assembles 16-bit MSB-first frames, decodes address/data and maintains a shadow copy of the MAX7219 register file. It is used for loopback checking of the driver on the FPGA and as a synthesizable device model in system benches.

## Interface
Parameters:
- SYNC_STAGES, 2, synchronizer depth for sclk_in/din_in/load_in (legal: 2 or 3)

Ports:
- clk  input  1  system clock; single clock domain
- rst_n  input  1  asynchronous active-low reset
- sclk_in  input  1  serial clock from transmitter; asynchronous to clk
- din_in  input  1  serial data, MSB first; valid on sclk_in rising edge
- load_in  input  1  frame strobe; low during shifting, rising edge latches the frame
- frame_valid  output  1  one-cycle pulse: a well-formed 16-bit frame was latched
- frame_err  output  1  one-cycle pulse: load_in rose with bit count != 16
- frame_addr  output  4  bits D11..D8 of the last valid frame
- frame_data  output  8  bits D7..D0 of the last valid frame
- rd_sel  input  3  digit register select (0..7 = digit 0..7)
- rd_digit  output  8  combinational read of the selected digit register
- decode_mode  output  8  register 0x9
- intensity  output  4  register 0xA, bits 3..0
- scan_limit  output  3  register 0xB, bits 2..0
- shutdown_n  output  1  register 0xC bit 0 (0 = shutdown)
- display_test  output  1  register 0xF bit 0

## Operation
- All three serial inputs pass through SYNC_STAGES flops plus one history flop; edges are detected on the synchronized copies. Synchronizer reset values: sclk 0, din 0, load 1.
- Input constraint: sclk_in high and low phases each >= SYNC_STAGES+1 clk periods; din_in stable around sclk_in rise by the same margin.
- FSM states: IDLE, SHIFT.
  - IDLE: sclk rises ignored. Synchronized load falling edge -> clear 16-bit shift register and 5-bit bit counter, go SHIFT.
  - SHIFT: each synchronized sclk rise shifts din into bit 0 (shift left), counter increments, saturating at 31. Synchronized load rising edge -> evaluate, go IDLE.
- Evaluation: counter == 16 -> frame_valid pulse, frame_addr/frame_data update, register write. Any other count -> frame_err pulse, no register or frame_* update.
- Register write by frame_addr: 0x0 no-op (frame_valid still pulses); 0x1..0x8 digit 0..7 = data; 0x9 decode_mode = data; 0xA intensity = data[3:0]; 0xB scan_limit = data[2:0]; 0xC shutdown_n = data[0]; 0xF display_test = data[0]; 0xD, 0xE ignored. D15..D12 don't care.
- Simultaneous sclk rise and load rise in the same cycle: the bit is shifted and counted first, then evaluated (a 15-bit frame plus that edge is accepted as 16).
- Reset values: frame_valid 0, frame_err 0, frame_addr 0, frame_data 0, all digits 0, decode_mode 0, intensity 0, scan_limit 0, shutdown_n 0, display_test 0, FSM IDLE.
- Reset mid-frame: partial frame discarded; if load_in is still low after release, FSM stays IDLE until a new falling edge (synchronizer load reset value 1 guarantees one is seen only on a real high-to-low transition after load returns high... or the first synchronized low following reset, which is treated as a falling edge and starts a fresh frame).

## Timing
- Latency, load_in rise to frame_valid: load sampled at edge E0; frame_valid, frame_* and register outputs all change at edge E0+SYNC_STAGES, high for exactly one cycle.
- frame_err has identical latency; never asserted together with frame_valid.
- rd_digit is combinational from rd_sel and the digit registers; register updates are visible in the same cycle frame_valid is high.
- Back-to-back frames: load high for >= SYNC_STAGES+1 clk periods between frames; no loss.

## Test plan
- Reset: hold rst_n low with random serial activity -> all outputs at reset values, no pulses; release with load high -> quiet.
- Single frame 0x0A05 (16 sclk, load rise) -> one frame_valid, frame_addr 0xA, frame_data 0x05, intensity 4'h5, others unchanged.
- Digit sweep: frames 0x01A0..0x08A7 -> rd_digit for rd_sel 0..7 reads 0xA0..0xA7; frame 0x0C01 -> shutdown_n 1; 0x0F01 -> display_test 1.
- Length errors: 15-bit frame and 17-bit frame -> frame_err pulse each, no register change, frame_addr/data hold previous valid values.
- Boundary: 15th... final sclk rise coincident with load rise at synchronizer output -> accepted as 16-bit frame; no-op frame 0x0000 -> frame_valid pulse, registers unchanged; addr 0xD/0xE -> frame_valid, no write.
- Async reset asserted after 8 bits of frame 0x0B07, released with load low, then new full frame 0x0B03 -> scan_limit 3, no error pulse from the aborted frame.

Source files
------------

// File: rtl/max7219_frame_rx.sv
// MAX7219 3-wire serial frame receiver with a shadow copy of the device register file.
// Samples LOAD/CLK/DIN in the system clock domain and decodes 16-bit MSB-first frames.
module max7219_frame_rx #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk_in,
    input  logic       din_in,
    input  logic       load_in,
    output logic       frame_valid,
    output logic       frame_err,
    output logic [3:0] frame_addr,
    output logic [7:0] frame_data,
    input  logic [2:0] rd_sel,
    output logic [7:0] rd_digit,
    output logic [7:0] decode_mode,
    output logic [3:0] intensity,
    output logic [2:0] scan_limit,
    output logic       shutdown_n,
    output logic       display_test
);

    typedef enum logic {StIdle, StShift} state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_din_sync;
    logic [SYNC_STAGES-1:0] r_load_sync;
    logic                   r_sclk_hist;
    logic                   r_load_hist;

    logic w_sclk;
    logic w_din;
    logic w_load;
    logic w_sclk_rise;
    logic w_load_rise;
    logic w_load_fall;

    // load resets high so a link held low through reset still yields a falling edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_din_sync  <= '0;
            r_load_sync <= '1;
            r_sclk_hist <= 1'b0;
            r_load_hist <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_in};
            r_din_sync  <= {r_din_sync[SYNC_STAGES-2:0], din_in};
            r_load_sync <= {r_load_sync[SYNC_STAGES-2:0], load_in};
            r_sclk_hist <= w_sclk;
            r_load_hist <= w_load;
        end
    end

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_din       = r_din_sync[SYNC_STAGES-1];
    assign w_load      = r_load_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_hist;
    assign w_load_rise = w_load & ~r_load_hist;
    assign w_load_fall = ~w_load & r_load_hist;

    state_t      r_state;
    state_t      w_state_next;
    // D15..D12 are don't-care, so only the low 12 frame bits are retained
    logic [11:0] r_shift;
    logic [11:0] w_shift_next;
    logic [4:0]  r_cnt;
    logic [4:0]  w_cnt_next;
    logic        w_eval;
    logic        w_frame_ok;
    logic [3:0]  w_addr;
    logic [7:0]  w_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_shift <= w_shift_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // A coincident sclk rise is shifted before the load rise is evaluated
    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_cnt_next   = r_cnt;
        w_eval       = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_load_fall) begin
                    w_shift_next = '0;
                    w_cnt_next   = '0;
                    w_state_next = StShift;
                end
            end
            StShift: begin
                if (w_sclk_rise) begin
                    w_shift_next = {r_shift[10:0], w_din};
                    if (r_cnt != 5'd31) begin
                        w_cnt_next = r_cnt + 5'd1;
                    end
                end
                if (w_load_rise) begin
                    w_eval       = 1'b1;
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign w_frame_ok = w_eval && (w_cnt_next == 5'd16);
    assign w_addr     = w_shift_next[11:8];
    assign w_data     = w_shift_next[7:0];

    logic       r_frame_valid;
    logic       r_frame_err;
    logic [3:0] r_frame_addr;
    logic [7:0] r_frame_data;
    logic [7:0] r_digit [0:7];
    logic [7:0] r_decode_mode;
    logic [3:0] r_intensity;
    logic [2:0] r_scan_limit;
    logic       r_shutdown_n;
    logic       r_display_test;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_valid  <= 1'b0;
            r_frame_err    <= 1'b0;
            r_frame_addr   <= '0;
            r_frame_data   <= '0;
            for (int i = 0; i < 8; i++) begin
                r_digit[i] <= '0;
            end
            r_decode_mode  <= '0;
            r_intensity    <= '0;
            r_scan_limit   <= '0;
            r_shutdown_n   <= 1'b0;
            r_display_test <= 1'b0;
        end else begin
            r_frame_valid <= w_frame_ok;
            r_frame_err   <= w_eval & ~w_frame_ok;
            if (w_frame_ok) begin
                r_frame_addr <= w_addr;
                r_frame_data <= w_data;
                for (int i = 0; i < 8; i++) begin
                    if (w_addr == 4'(i + 1)) begin
                        r_digit[i] <= w_data;
                    end
                end
                case (w_addr)
                    4'h9:    r_decode_mode  <= w_data;
                    4'hA:    r_intensity    <= w_data[3:0];
                    4'hB:    r_scan_limit   <= w_data[2:0];
                    4'hC:    r_shutdown_n   <= w_data[0];
                    4'hF:    r_display_test <= w_data[0];
                    default: ;
                endcase
            end
        end
    end

    assign frame_valid  = r_frame_valid;
    assign frame_err    = r_frame_err;
    assign frame_addr   = r_frame_addr;
    assign frame_data   = r_frame_data;
    assign rd_digit     = r_digit[rd_sel];
    assign decode_mode  = r_decode_mode;
    assign intensity    = r_intensity;
    assign scan_limit   = r_scan_limit;
    assign shutdown_n   = r_shutdown_n;
    assign display_test = r_display_test;

endmodule

// File: tb/tb_max7219_frame_rx.sv
// Self-checking bench for max7219_frame_rx: scoreboard of expected frame pulses plus
// per-scenario register checks.
module tb_max7219_frame_rx;

    localparam int unsigned SS = 2;

    logic       clk;
    logic       rst_n;
    logic       sclk_in;
    logic       din_in;
    logic       load_in;
    logic       frame_valid;
    logic       frame_err;
    logic [3:0] frame_addr;
    logic [7:0] frame_data;
    logic [2:0] rd_sel;
    logic [7:0] rd_digit;
    logic [7:0] decode_mode;
    logic [3:0] intensity;
    logic [2:0] scan_limit;
    logic       shutdown_n;
    logic       display_test;

    max7219_frame_rx #(.SYNC_STAGES(SS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sclk_in      (sclk_in),
        .din_in       (din_in),
        .load_in      (load_in),
        .frame_valid  (frame_valid),
        .frame_err    (frame_err),
        .frame_addr   (frame_addr),
        .frame_data   (frame_data),
        .rd_sel       (rd_sel),
        .rd_digit     (rd_digit),
        .decode_mode  (decode_mode),
        .intensity    (intensity),
        .scan_limit   (scan_limit),
        .shutdown_n   (shutdown_n),
        .display_test (display_test)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       is_err;
        logic [3:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       m_e;
    int         checks = 0;
    int         errors = 0;
    logic [3:0] last_addr = '0;
    logic [7:0] last_data = '0;

    // Pulse monitor: every frame_valid/frame_err must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && (frame_valid || frame_err)) begin
            checks++;
            if (frame_valid && frame_err) begin
                errors++;
                $display("FAIL both_pulses valid=%b err=%b required one of them", frame_valid,
                         frame_err);
            end else if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse valid=%b err=%b addr=%h data=%h required none",
                         frame_valid, frame_err, frame_addr, frame_data);
            end else begin
                m_e = sb_q.pop_front();
                if ({frame_err, frame_addr, frame_data} !== {m_e.is_err, m_e.addr, m_e.data}) begin
                    errors++;
                    $display("FAIL sb_frame got err=%b addr=%h data=%h required err=%b addr=%h data=%h",
                             frame_err, frame_addr, frame_data, m_e.is_err, m_e.addr, m_e.data);
                end
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_valid(input logic [3:0] addr, input logic [7:0] data);
        sb_q.push_back({1'b0, addr, data});
        last_addr = addr;
        last_data = data;
    endtask

    task automatic push_err();
        sb_q.push_back({1'b1, last_addr, last_data});
    endtask

    // Shifts n bits MSB first; optionally raises load together with the final sclk rise.
    // lat = negedge index (from load rise) of the first pulse, 0 if no pulse occurs.
    task automatic send_bits(input logic [31:0] bits, input int n, input bit coincident,
                             output int lat);
        @(posedge clk);
        #1;
        load_in = 1'b0;
        wait_clk(4);
        for (int i = n - 1; i >= 0; i--) begin
            din_in = bits[i];
            wait_clk(4);
            sclk_in = 1'b1;
            if (coincident && i == 0) begin
                load_in = 1'b1;
            end else begin
                wait_clk(4);
                sclk_in = 1'b0;
            end
        end
        if (!coincident) begin
            wait_clk(4);
            load_in = 1'b1;
        end
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (lat == 0 && (frame_valid || frame_err)) lat = k;
        end
        #1;
        sclk_in = 1'b0;
        wait_clk(2);
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 50 && sb_q.size() != 0; k++) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain_%s pending=%0d required 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            sclk_in = 1'($urandom_range(0, 1));
            din_in  = 1'($urandom_range(0, 1));
            load_in = 1'($urandom_range(0, 1));
            rd_sel  = 3'($urandom_range(0, 7));
            @(negedge clk);
            checks++;
            if ({frame_valid, frame_err, frame_addr, frame_data, rd_digit, decode_mode, intensity,
                 scan_limit, shutdown_n, display_test} !== 38'd0) begin
                errors++;
                $display("FAIL reset_state cycle=%0d valid=%b err=%b addr=%h data=%h digit=%h dec=%h int=%h scan=%h shdn=%b test=%b required all 0",
                         c, frame_valid, frame_err, frame_addr, frame_data, rd_digit, decode_mode,
                         intensity, scan_limit, shutdown_n, display_test);
            end
        end
        @(posedge clk);
        #1;
        sclk_in = 1'b0;
        din_in  = 1'b0;
        load_in = 1'b1;
        rd_sel  = 3'd0;
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(12);
        wait_drain("reset");
    endtask

    task automatic test_single();
        int lat;
        push_valid(4'hA, 8'h05);
        send_bits(32'h0A05, 16, 1'b0, lat);
        checks++;
        if (lat != int'(SS) + 2) begin
            errors++;
            $display("FAIL latency got=%0d required=%0d", lat, SS + 2);
        end
        wait_drain("single");
        checks++;
        if ({intensity, decode_mode, scan_limit, shutdown_n, display_test} !== {4'h5, 8'h00, 3'h0,
             1'b0, 1'b0}) begin
            errors++;
            $display("FAIL single_regs int=%h dec=%h scan=%h shdn=%b test=%b required 5/00/0/0/0",
                     intensity, decode_mode, scan_limit, shutdown_n, display_test);
        end
    endtask

    task automatic test_digits();
        int         lat;
        logic [7:0] exp_d;
        for (int d = 0; d < 8; d++) begin
            push_valid(4'(d + 1), 8'hA0 + 8'(d));
            send_bits({16'h0, 4'h0, 4'(d + 1), 8'hA0 + 8'(d)}, 16, 1'b0, lat);
        end
        wait_drain("digits");
        for (int s = 0; s < 8; s++) begin
            rd_sel = 3'(s);
            exp_d  = 8'hA0 + 8'(s);
            #1;
            checks++;
            if (rd_digit !== exp_d) begin
                errors++;
                $display("FAIL digit_read sel=%0d got=%h required=%h", s, rd_digit, exp_d);
            end
        end
        push_valid(4'hC, 8'h01);
        send_bits(32'h0C01, 16, 1'b0, lat);
        wait_drain("shutdown");
        checks++;
        if (shutdown_n !== 1'b1) begin
            errors++;
            $display("FAIL shutdown_n got=%b required=1", shutdown_n);
        end
        push_valid(4'hF, 8'h01);
        send_bits(32'h0F01, 16, 1'b0, lat);
        wait_drain("disptest");
        checks++;
        if (display_test !== 1'b1) begin
            errors++;
            $display("FAIL display_test got=%b required=1", display_test);
        end
    endtask

    task automatic test_len_err();
        int lat;
        push_err();
        send_bits(32'h0A33, 15, 1'b0, lat);
        wait_drain("err15");
        checks++;
        if ({intensity, frame_addr, frame_data} !== {4'h5, 4'hF, 8'h01}) begin
            errors++;
            $display("FAIL err15_hold int=%h addr=%h data=%h required 5/F/01", intensity,
                     frame_addr, frame_data);
        end
        push_err();
        send_bits(32'h00A66, 17, 1'b0, lat);
        wait_drain("err17");
        checks++;
        if ({intensity, frame_addr, frame_data} !== {4'h5, 4'hF, 8'h01}) begin
            errors++;
            $display("FAIL err17_hold int=%h addr=%h data=%h required 5/F/01", intensity,
                     frame_addr, frame_data);
        end
    endtask

    task automatic test_boundary();
        int lat;
        push_valid(4'hB, 8'h05);
        send_bits(32'h0B05, 16, 1'b1, lat);
        wait_drain("coincident");
        checks++;
        if (scan_limit !== 3'h5) begin
            errors++;
            $display("FAIL coincident_scan got=%h required=5", scan_limit);
        end
        push_valid(4'h0, 8'h00);
        send_bits(32'h0000, 16, 1'b0, lat);
        push_valid(4'hD, 8'h42);
        send_bits(32'h0D42, 16, 1'b0, lat);
        push_valid(4'hE, 8'h42);
        send_bits(32'h0E42, 16, 1'b0, lat);
        wait_drain("noop");
        rd_sel = 3'd0;
        #1;
        checks++;
        if ({intensity, scan_limit, decode_mode, rd_digit, shutdown_n, display_test} !==
            {4'h5, 3'h5, 8'h00, 8'hA0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL noop_regs int=%h scan=%h dec=%h dig0=%h shdn=%b test=%b required 5/5/00/A0/1/1",
                     intensity, scan_limit, decode_mode, rd_digit, shutdown_n, display_test);
        end
        push_valid(4'h9, 8'h42);
        send_bits(32'h0942, 16, 1'b0, lat);
        push_valid(4'hA, 8'h07);
        send_bits(32'hFA07, 16, 1'b0, lat);
        wait_drain("dontcare");
        checks++;
        if ({decode_mode, intensity} !== {8'h42, 4'h7}) begin
            errors++;
            $display("FAIL decode_intensity dec=%h int=%h required 42/7", decode_mode, intensity);
        end
    endtask

    task automatic test_reset_mid();
        int          lat;
        logic [15:0] word;
        word = 16'h0B07;
        @(posedge clk);
        #1;
        load_in = 1'b0;
        wait_clk(4);
        for (int i = 15; i >= 8; i--) begin
            din_in = word[i];
            wait_clk(4);
            sclk_in = 1'b1;
            wait_clk(4);
            sclk_in = 1'b0;
        end
        wait_clk(2);
        rst_n = 1'b0;
        wait_clk(3);
        checks++;
        if ({scan_limit, intensity, frame_addr} !== {3'h0, 4'h0, 4'h0}) begin
            errors++;
            $display("FAIL mid_reset_clear scan=%h int=%h addr=%h required 0/0/0", scan_limit,
                     intensity, frame_addr);
        end
        rst_n     = 1'b1;
        last_addr = '0;
        last_data = '0;
        wait_clk(6);
        push_valid(4'hB, 8'h03);
        send_bits(32'h0B03, 16, 1'b0, lat);
        wait_drain("after_reset");
        checks++;
        if ({scan_limit, intensity} !== {3'h3, 4'h0}) begin
            errors++;
            $display("FAIL after_reset_regs scan=%h int=%h required 3/0", scan_limit, intensity);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        sclk_in = 1'b0;
        din_in  = 1'b0;
        load_in = 1'b1;
        rd_sel  = 3'd0;
        test_reset();
        test_single();
        test_digits();
        test_len_err();
        test_boundary();
        test_reset_mid();
        wait_clk(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout sim_time=%0t required finish", $time);
        $fatal(1, "timeout");
    end

endmodule
